// File: rtl/bp_cce_hybrid_req_router.sv
// Steers LCE request bursts (header + optional data beats) to the cached or uncached pipe.
// Define BP_CCE_HYBRID_ROUTER_SKID_EN to add a 1-entry registered header buffer (1-cycle header latency).
//
// state            | meaning
// e_ready          | waiting for / forwarding a request header
// e_data_cached    | forwarding data beats of the current burst to the cached pipe
// e_data_uncached  | forwarding data beats of the current burst to the uncached pipe
//
// Header layout, LSB first: msg_type[3:0], subop[7:4], addr[8 +: paddr_width_p], size[2:0], lce_id.
module bp_cce_hybrid_req_router
  #(parameter int paddr_width_p     = 40
   ,parameter int lce_id_width_p    = 8
   ,parameter int lce_data_width_p  = 64
   ,parameter int cce_block_width_p = 512
   ,parameter logic [paddr_width_p-1:0] cacheable_addr_lo_p = 40'h00_8000_0000
   ,parameter logic [paddr_width_p-1:0] cacheable_addr_hi_p = 40'hFF_FFFF_FFFF
   ,localparam int lce_req_msg_header_width_lp = lce_id_width_p + 3 + paddr_width_p + 8
   )
   (input  logic                                   clk_i
   ,input  logic                                   reset_i

   ,input  logic [lce_req_msg_header_width_lp-1:0] lce_req_header_i
   ,input  logic                                   lce_req_header_v_i
   ,output logic                                   lce_req_header_ready_and_o
   ,input  logic                                   lce_req_has_data_i
   ,input  logic [lce_data_width_p-1:0]            lce_req_data_i
   ,input  logic                                   lce_req_data_v_i
   ,output logic                                   lce_req_data_ready_and_o
   ,input  logic                                   lce_req_last_i

   ,output logic [lce_req_msg_header_width_lp-1:0] cached_header_o
   ,output logic                                   cached_header_v_o
   ,input  logic                                   cached_header_ready_and_i
   ,output logic                                   cached_has_data_o
   ,output logic [lce_data_width_p-1:0]            cached_data_o
   ,output logic                                   cached_data_v_o
   ,input  logic                                   cached_data_ready_and_i
   ,output logic                                   cached_last_o

   ,output logic [lce_req_msg_header_width_lp-1:0] uncached_header_o
   ,output logic                                   uncached_header_v_o
   ,input  logic                                   uncached_header_ready_and_i
   ,output logic                                   uncached_has_data_o
   ,output logic [lce_data_width_p-1:0]            uncached_data_o
   ,output logic                                   uncached_data_v_o
   ,input  logic                                   uncached_data_ready_and_i
   ,output logic                                   uncached_last_o

   ,output logic                                   idle_o
   );

    localparam int hw_lp            = lce_req_msg_header_width_lp;
    localparam int beats_lp         = cce_block_width_p / lce_data_width_p;
    localparam int beat_cnt_width_lp = ((beats_lp > 1) ? $clog2(beats_lp) : 1) + 1;

    typedef enum logic [3:0] {
        e_bedrock_req_rd_miss = 4'd0,
        e_bedrock_req_wr_miss = 4'd1,
        e_bedrock_req_uc_rd   = 4'd2,
        e_bedrock_req_uc_wr   = 4'd3,
        e_bedrock_req_uc_amo  = 4'd4
    } bp_bedrock_req_type_e;

    typedef enum logic [1:0] {e_ready, e_data_cached, e_data_uncached} state_e;

    // Only coherent misses to the cacheable window go cached; everything else, including unknown types, is uncached.
    function automatic logic route_cached(input logic [3:0] msg_type, input logic [paddr_width_p-1:0] addr);
        logic [paddr_width_p:0] below_lo;
        logic [paddr_width_p:0] above_hi;
        below_lo = {1'b0, addr} - {1'b0, cacheable_addr_lo_p};
        above_hi = {1'b0, cacheable_addr_hi_p} - {1'b0, addr};
        return ((msg_type == e_bedrock_req_rd_miss) || (msg_type == e_bedrock_req_wr_miss))
               && !below_lo[paddr_width_p] && !above_hi[paddr_width_p];
    endfunction

    state_e                       state_r;
    logic [beat_cnt_width_lp-1:0] beat_cnt_r;

    logic [hw_lp-1:0] hdr_fwd;
    logic             hdr_fwd_v;
    logic             hdr_fwd_has_data;
    logic             hdr_fwd_cached;
    logic             hdr_sel_ready;
    logic             hdr_in_ready;
    logic             hdr_out_hs;
    logic             buf_busy;
    logic             data_hs;

    assign hdr_sel_ready = hdr_fwd_cached ? cached_header_ready_and_i : uncached_header_ready_and_i;
    assign hdr_out_hs    = ~reset_i & (state_r == e_ready) & hdr_fwd_v & hdr_sel_ready;
    assign data_hs       = lce_req_data_v_i & lce_req_data_ready_and_o;

`ifdef BP_CCE_HYBRID_ROUTER_SKID_EN
    logic [hw_lp-1:0] buf_header_r;
    logic             buf_v_r;
    logic             buf_has_data_r;
    logic             buf_cached_r;
    logic             hdr_in_hs;

    assign hdr_fwd          = buf_header_r;
    assign hdr_fwd_v        = buf_v_r;
    assign hdr_fwd_has_data = buf_has_data_r;
    assign hdr_fwd_cached   = buf_cached_r;
    assign hdr_in_ready     = ~buf_v_r | hdr_out_hs;
    assign hdr_in_hs        = lce_req_header_v_i & lce_req_header_ready_and_o;
    assign buf_busy         = buf_v_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_v_r <= 1'b0;
        end else if (hdr_in_hs) begin
            buf_v_r        <= 1'b1;
            buf_header_r   <= lce_req_header_i;
            buf_has_data_r <= lce_req_has_data_i;
            buf_cached_r   <= route_cached(lce_req_header_i[3:0], lce_req_header_i[8 +: paddr_width_p]);
        end else if (hdr_out_hs) begin
            buf_v_r <= 1'b0;
        end
    end
`else
    assign hdr_fwd          = lce_req_header_i;
    assign hdr_fwd_v        = lce_req_header_v_i;
    assign hdr_fwd_has_data = lce_req_has_data_i;
    assign hdr_fwd_cached   = route_cached(lce_req_header_i[3:0], lce_req_header_i[8 +: paddr_width_p]);
    assign hdr_in_ready     = hdr_sel_ready;
    assign buf_busy         = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_ready;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (hdr_out_hs && hdr_fwd_has_data) begin
                        state_r    <= hdr_fwd_cached ? e_data_cached : e_data_uncached;
                        beat_cnt_r <= '0;
                    end
                end
                e_data_cached, e_data_uncached: begin
                    if (data_hs) begin
                        // A burst longer than one cache block is an upstream protocol error.
                        assert (beat_cnt_r < beat_cnt_width_lp'(beats_lp));
                        beat_cnt_r <= beat_cnt_r + beat_cnt_width_lp'(1);
                        if (lce_req_last_i) state_r <= e_ready;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    // All outputs are forced low while reset is held; the unselected channel always stays quiet.
    always_comb begin
        lce_req_header_ready_and_o = 1'b0;
        lce_req_data_ready_and_o   = 1'b0;
        cached_header_o     = '0;
        cached_header_v_o   = 1'b0;
        cached_has_data_o   = 1'b0;
        cached_data_o       = '0;
        cached_data_v_o     = 1'b0;
        cached_last_o       = 1'b0;
        uncached_header_o   = '0;
        uncached_header_v_o = 1'b0;
        uncached_has_data_o = 1'b0;
        uncached_data_o     = '0;
        uncached_data_v_o   = 1'b0;
        uncached_last_o     = 1'b0;
        if (!reset_i) begin
            case (state_r)
                e_ready: begin
                    lce_req_header_ready_and_o = hdr_in_ready;
                    if (hdr_fwd_v && hdr_fwd_cached) begin
                        cached_header_v_o = 1'b1;
                        cached_header_o   = hdr_fwd;
                        cached_has_data_o = hdr_fwd_has_data;
                    end else if (hdr_fwd_v) begin
                        uncached_header_v_o = 1'b1;
                        uncached_header_o   = hdr_fwd;
                        uncached_has_data_o = hdr_fwd_has_data;
                    end
                end
                e_data_cached: begin
                    lce_req_data_ready_and_o = cached_data_ready_and_i;
                    cached_data_v_o = lce_req_data_v_i;
                    cached_data_o   = lce_req_data_i;
                    cached_last_o   = lce_req_last_i;
                end
                e_data_uncached: begin
                    lce_req_data_ready_and_o = uncached_data_ready_and_i;
                    uncached_data_v_o = lce_req_data_v_i;
                    uncached_data_o   = lce_req_data_i;
                    uncached_last_o   = lce_req_last_i;
                end
                default: ;
            endcase
        end
    end

    assign idle_o = reset_i | ((state_r == e_ready) & ~buf_busy);

endmodule

// File: tb/tb_bp_cce_hybrid_req_router.sv
// Directed bench for bp_cce_hybrid_req_router: routing, bursts with stalls, back-to-back headers, reset.
// Expected header latency follows BP_CCE_HYBRID_ROUTER_SKID_EN.
module tb_bp_cce_hybrid_req_router;

    localparam int HW = 59;
    localparam int DW = 64;

`ifdef BP_CCE_HYBRID_ROUTER_SKID_EN
    localparam int HDR_LAT = 1;
`else
    localparam int HDR_LAT = 0;
`endif

    localparam logic [3:0] RD_MISS = 4'd0;
    localparam logic [3:0] WR_MISS = 4'd1;
    localparam logic [3:0] UC_RD   = 4'd2;
    localparam logic [3:0] UC_WR   = 4'd3;
    localparam logic [3:0] UC_AMO  = 4'd4;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [HW-1:0] lce_req_header_i;
    logic          lce_req_header_v_i;
    logic          lce_req_header_ready_and_o;
    logic          lce_req_has_data_i;
    logic [DW-1:0] lce_req_data_i;
    logic          lce_req_data_v_i;
    logic          lce_req_data_ready_and_o;
    logic          lce_req_last_i;
    logic [HW-1:0] cached_header_o;
    logic          cached_header_v_o;
    logic          cached_header_ready_and_i;
    logic          cached_has_data_o;
    logic [DW-1:0] cached_data_o;
    logic          cached_data_v_o;
    logic          cached_data_ready_and_i;
    logic          cached_last_o;
    logic [HW-1:0] uncached_header_o;
    logic          uncached_header_v_o;
    logic          uncached_header_ready_and_i;
    logic          uncached_has_data_o;
    logic [DW-1:0] uncached_data_o;
    logic          uncached_data_v_o;
    logic          uncached_data_ready_and_i;
    logic          uncached_last_o;
    logic          idle_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] bt_data [8];
    logic          bt_last [8];
    int            bt_got, bt_bad, bt_leak;

    always #5 clk_i = ~clk_i;

    bp_cce_hybrid_req_router dut (
        .clk_i                       (clk_i),
        .reset_i                     (reset_i),
        .lce_req_header_i            (lce_req_header_i),
        .lce_req_header_v_i          (lce_req_header_v_i),
        .lce_req_header_ready_and_o  (lce_req_header_ready_and_o),
        .lce_req_has_data_i          (lce_req_has_data_i),
        .lce_req_data_i              (lce_req_data_i),
        .lce_req_data_v_i            (lce_req_data_v_i),
        .lce_req_data_ready_and_o    (lce_req_data_ready_and_o),
        .lce_req_last_i              (lce_req_last_i),
        .cached_header_o             (cached_header_o),
        .cached_header_v_o           (cached_header_v_o),
        .cached_header_ready_and_i   (cached_header_ready_and_i),
        .cached_has_data_o           (cached_has_data_o),
        .cached_data_o               (cached_data_o),
        .cached_data_v_o             (cached_data_v_o),
        .cached_data_ready_and_i     (cached_data_ready_and_i),
        .cached_last_o               (cached_last_o),
        .uncached_header_o           (uncached_header_o),
        .uncached_header_v_o         (uncached_header_v_o),
        .uncached_header_ready_and_i (uncached_header_ready_and_i),
        .uncached_has_data_o         (uncached_has_data_o),
        .uncached_data_o             (uncached_data_o),
        .uncached_data_v_o           (uncached_data_v_o),
        .uncached_data_ready_and_i   (uncached_data_ready_and_i),
        .uncached_last_o             (uncached_last_o),
        .idle_o                      (idle_o)
    );

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [39:0] a, input logic [7:0] id);
        return {id, 3'd3, a, 4'd0, t};
    endfunction

    // Presents one header and reports the first cycle a header appears on either output.
    task automatic send_header(input logic [HW-1:0] hdr, input logic hd, output int lat,
                               output logic got_c, output logic got_u,
                               output logic [HW-1:0] seen, output logic seen_hd);
        logic accepted;
        lat = -1; got_c = 1'b0; got_u = 1'b0; seen = '0; seen_hd = 1'b0;
        @(negedge clk_i);
        lce_req_header_i   = hdr;
        lce_req_has_data_i = hd;
        lce_req_header_v_i = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            accepted = lce_req_header_v_i & lce_req_header_ready_and_o;
            if (cached_header_v_o === 1'b1 || uncached_header_v_o === 1'b1) begin
                lat     = cyc;
                got_c   = cached_header_v_o;
                got_u   = uncached_header_v_o;
                seen    = cached_header_v_o ? cached_header_o : uncached_header_o;
                seen_hd = cached_header_v_o ? cached_has_data_o : uncached_has_data_o;
            end
            @(posedge clk_i);
            #1;
            if (accepted) begin
                lce_req_header_v_i = 1'b0;
                lce_req_has_data_i = 1'b0;
            end
            if (lat >= 0) break;
            @(negedge clk_i);
        end
        lce_req_header_v_i = 1'b0;
    endtask

    // Drives n beats (value base+i) and records what the selected channel delivers on each accepted beat.
    task automatic send_beats(input int n, input logic [DW-1:0] base, input logic to_cached, input logic toggle);
        int   beat;
        logic rdy, ch_v, other_v;
        beat = 0; bt_bad = 0; bt_leak = 0;
        for (int i = 0; i < 8; i++) begin
            bt_data[i] = '0;
            bt_last[i] = 1'b0;
        end
        @(negedge clk_i);
        for (int cyc = 0; cyc < 40; cyc++) begin
            rdy = toggle ? cyc[0] : 1'b1;
            lce_req_data_i   = base + DW'(beat);
            lce_req_data_v_i = 1'b1;
            lce_req_last_i   = (beat == n - 1);
            cached_data_ready_and_i   = to_cached ? rdy : 1'b1;
            uncached_data_ready_and_i = to_cached ? 1'b1 : rdy;
            #1;
            ch_v    = to_cached ? cached_data_v_o : uncached_data_v_o;
            other_v = to_cached ? uncached_data_v_o : cached_data_v_o;
            if (ch_v !== 1'b1 || other_v !== 1'b0 || lce_req_data_ready_and_o !== rdy) bt_bad++;
            if ({lce_req_header_ready_and_o, cached_header_v_o, uncached_header_v_o} !== 3'b000) bt_leak++;
            if (rdy) begin
                if (beat < 8) begin
                    bt_data[beat] = to_cached ? cached_data_o : uncached_data_o;
                    bt_last[beat] = to_cached ? cached_last_o : uncached_last_o;
                end
                beat++;
            end
            @(posedge clk_i);
            #1;
            if (beat == n) break;
            @(negedge clk_i);
        end
        bt_got = beat;
        lce_req_data_v_i = 1'b0;
        lce_req_last_i   = 1'b0;
        lce_req_data_i   = '0;
        cached_data_ready_and_i   = 1'b1;
        uncached_data_ready_and_i = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        lce_req_header_i   = mk_hdr(RD_MISS, 40'h00_8000_1000, 8'h01);
        lce_req_header_v_i = 1'b1;
        lce_req_has_data_i = 1'b1;
        lce_req_data_i     = 64'h1234_5678_9ABC_DEF0;
        lce_req_data_v_i   = 1'b1;
        lce_req_last_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        n_tests++;
        if ({cached_header_v_o, cached_data_v_o, uncached_header_v_o, uncached_data_v_o,
             lce_req_header_ready_and_o, lce_req_data_ready_and_o, cached_last_o, uncached_last_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got v/ready/last vector nonzero (chv=%b cdv=%b uhv=%b udv=%b hr=%b dr=%b), required all 0",
                     cached_header_v_o, cached_data_v_o, uncached_header_v_o, uncached_data_v_o,
                     lce_req_header_ready_and_o, lce_req_data_ready_and_o);
        end
        n_tests++;
        if ({cached_header_o, uncached_header_o, cached_data_o, uncached_data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got cached_header_o=%h cached_data_o=%h, required 0", cached_header_o, cached_data_o);
        end
        n_tests++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle: got %b, required 1", idle_o);
        end
        lce_req_header_v_i = 1'b0;
        lce_req_has_data_i = 1'b0;
        lce_req_data_v_i   = 1'b0;
        lce_req_last_i     = 1'b0;
        lce_req_data_i     = '0;
        reset_i            = 1'b0;
        @(posedge clk_i);
    endtask

    task automatic test_rd_miss();
        int lat; logic gc, gu, shd; logic [HW-1:0] h, s;
        h = mk_hdr(RD_MISS, 40'h00_8000_1000, 8'h05);
        send_header(h, 1'b0, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu} !== 2'b10) begin
            n_fail++;
            $display("FAIL rd_miss_route: got cached_v=%b uncached_v=%b, required 1/0", gc, gu);
        end
        n_tests++;
        if (s !== h) begin
            n_fail++;
            $display("FAIL rd_miss_header: got %h, required %h", s, h);
        end
        n_tests++;
        if (shd !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_miss_has_data: got %b, required 0", shd);
        end
        n_tests++;
        if (lat !== HDR_LAT) begin
            n_fail++;
            $display("FAIL rd_miss_latency: got %0d, required %0d", lat, HDR_LAT);
        end
        @(negedge clk_i);
        #1;
        n_tests++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_miss_idle: got %b, required 1", idle_o);
        end
    endtask

    task automatic test_uc_wr_one_beat();
        int lat; logic gc, gu, shd; logic [HW-1:0] h, s;
        h = mk_hdr(UC_WR, 40'h00_0010_0000, 8'h02);
        send_header(h, 1'b1, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu, shd} !== 3'b011) begin
            n_fail++;
            $display("FAIL uc_wr_route: got cached_v=%b uncached_v=%b has_data=%b, required 0/1/1", gc, gu, shd);
        end
        n_tests++;
        if (s !== h || lat !== HDR_LAT) begin
            n_fail++;
            $display("FAIL uc_wr_header: got %h lat %0d, required %h lat %0d", s, lat, h, HDR_LAT);
        end
        send_beats(1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
        n_tests++;
        if (bt_got !== 1 || bt_bad !== 0) begin
            n_fail++;
            $display("FAIL uc_wr_beat_flow: got %0d beats %0d bad cycles, required 1 beat 0 bad", bt_got, bt_bad);
        end
        n_tests++;
        if (bt_data[0] !== 64'h0000_0000_DEAD_BEEF || bt_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL uc_wr_data: got %h last %b, required deadbeef last 1", bt_data[0], bt_last[0]);
        end
        @(negedge clk_i);
        #1;
        n_tests++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL uc_wr_idle: got %b, required 1", idle_o);
        end
    endtask

    task automatic test_classification();
        logic [3:0]  tt [7];
        logic [39:0] aa [7];
        logic        ec [7];
        int lat; logic gc, gu, shd; logic [HW-1:0] s;
        tt = '{WR_MISS, RD_MISS, WR_MISS, RD_MISS, UC_RD, UC_AMO, 4'hA};
        aa = '{40'h00_4000_0000, 40'h00_8000_0000, 40'h00_7FFF_FFFF, 40'hFF_FFFF_FFFF,
               40'h00_9000_0000, 40'h00_9000_0000, 40'h00_9000_0000};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            send_header(mk_hdr(tt[i], aa[i], 8'h10), 1'b0, lat, gc, gu, s, shd);
            n_tests++;
            if ({gc, gu} !== {ec[i], ~ec[i]}) begin
                n_fail++;
                $display("FAIL classify_%0d: type %0d addr %h got cached_v=%b uncached_v=%b, required %b/%b",
                         i, tt[i], aa[i], gc, gu, ec[i], ~ec[i]);
            end
        end
    endtask

    task automatic test_burst_stall();
        int lat; logic gc, gu, shd; logic [HW-1:0] h, h2, s;
        h  = mk_hdr(WR_MISS, 40'h00_8000_2000, 8'h01);
        h2 = mk_hdr(RD_MISS, 40'h00_8000_3000, 8'h03);
        send_header(h, 1'b1, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu} !== 2'b10 || s !== h) begin
            n_fail++;
            $display("FAIL burst_header: got cached_v=%b header %h, required 1 header %h", gc, s, h);
        end
        lce_req_header_i   = h2;
        lce_req_has_data_i = 1'b0;
        lce_req_header_v_i = 1'b1;
        send_beats(8, 64'h0000_0000_0000_1000, 1'b1, 1'b1);
        lce_req_header_v_i = 1'b0;
        n_tests++;
        if (bt_got !== 8 || bt_bad !== 0) begin
            n_fail++;
            $display("FAIL burst_flow: got %0d beats %0d bad cycles, required 8 beats 0 bad", bt_got, bt_bad);
        end
        n_tests++;
        if (bt_leak !== 0) begin
            n_fail++;
            $display("FAIL burst_header_blocked: got %0d cycles with header activity, required 0", bt_leak);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bt_data[i] !== 64'h1000 + 64'(i) || bt_last[i] !== (i == 7)) begin
                n_fail++;
                $display("FAIL burst_beat_%0d: got %h last %b, required %h last %b",
                         i, bt_data[i], bt_last[i], 64'h1000 + 64'(i), (i == 7));
            end
        end
        send_header(h2, 1'b0, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu} !== 2'b10 || s !== h2 || lat !== HDR_LAT) begin
            n_fail++;
            $display("FAIL burst_held_header: got cached_v=%b header %h lat %0d, required 1 header %h lat %0d",
                     gc, s, lat, h2, HDR_LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [HW-1:0] h [4];
        logic          ec [4];
        int idx;
        h[0] = mk_hdr(RD_MISS, 40'h00_8000_0040, 8'h20); ec[0] = 1'b1;
        h[1] = mk_hdr(UC_RD,   40'h00_8000_0080, 8'h21); ec[1] = 1'b0;
        h[2] = mk_hdr(WR_MISS, 40'h00_8000_00C0, 8'h22); ec[2] = 1'b1;
        h[3] = mk_hdr(UC_WR,   40'h00_0000_0100, 8'h23); ec[3] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (k < 4) begin
                lce_req_header_i   = h[k];
                lce_req_has_data_i = 1'b0;
                lce_req_header_v_i = 1'b1;
            end else begin
                lce_req_header_v_i = 1'b0;
            end
            #1;
            if (k < 4) begin
                n_tests++;
                if (lce_req_header_ready_and_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready_%0d: got %b, required 1", k, lce_req_header_ready_and_o);
                end
            end
            idx = k - HDR_LAT;
            if (idx >= 0 && idx < 4) begin
                n_tests++;
                if ({cached_header_v_o, uncached_header_v_o} !== {ec[idx], ~ec[idx]} ||
                    (ec[idx] ? cached_header_o : uncached_header_o) !== h[idx]) begin
                    n_fail++;
                    $display("FAIL b2b_out_%0d: got cached_v=%b uncached_v=%b header %h, required %b/%b header %h",
                             idx, cached_header_v_o, uncached_header_v_o,
                             ec[idx] ? cached_header_o : uncached_header_o, ec[idx], ~ec[idx], h[idx]);
                end
            end
        end
        @(negedge clk_i);
        #1;
        n_tests++;
        if (idle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b, required 1", idle_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        int lat; logic gc, gu, shd; logic [HW-1:0] h, s;
        send_header(mk_hdr(UC_WR, 40'h00_0020_0000, 8'h30), 1'b1, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_burst_route: got cached_v=%b uncached_v=%b, required 0/1", gc, gu);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk_i);
            lce_req_data_i   = 64'hA000 + 64'(b);
            lce_req_data_v_i = 1'b1;
            lce_req_last_i   = 1'b0;
        end
        @(negedge clk_i);
        lce_req_data_i = 64'hA002;
        reset_i        = 1'b1;
        #1;
        n_tests++;
        if (uncached_data_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_burst_during: got uncached_data_v_o=%b, required 0", uncached_data_v_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        n_tests++;
        if ({cached_header_v_o, cached_data_v_o, uncached_header_v_o, uncached_data_v_o,
             lce_req_data_ready_and_o, idle_o} !== 6'b000001) begin
            n_fail++;
            $display("FAIL rst_burst_after: got chv=%b cdv=%b uhv=%b udv=%b dready=%b idle=%b, required 0 0 0 0 0 1",
                     cached_header_v_o, cached_data_v_o, uncached_header_v_o, uncached_data_v_o,
                     lce_req_data_ready_and_o, idle_o);
        end
        lce_req_data_v_i = 1'b0;
        lce_req_data_i   = '0;
        h = mk_hdr(RD_MISS, 40'h00_8000_4000, 8'h31);
        send_header(h, 1'b0, lat, gc, gu, s, shd);
        n_tests++;
        if ({gc, gu} !== 2'b10 || s !== h || lat !== HDR_LAT) begin
            n_fail++;
            $display("FAIL rst_burst_new_header: got cached_v=%b header %h lat %0d, required 1 header %h lat %0d",
                     gc, s, lat, h, HDR_LAT);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        lce_req_header_i = '0;
        lce_req_header_v_i = 1'b0;
        lce_req_has_data_i = 1'b0;
        lce_req_data_i = '0;
        lce_req_data_v_i = 1'b0;
        lce_req_last_i = 1'b0;
        cached_header_ready_and_i = 1'b1;
        cached_data_ready_and_i = 1'b1;
        uncached_header_ready_and_i = 1'b1;
        uncached_data_ready_and_i = 1'b1;

        test_reset();
        test_rd_miss();
        test_uc_wr_one_beat();
        test_classification();
        test_burst_stall();
        test_back_to_back();
        test_reset_mid_burst();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
